// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants for the OP-IMM encoder.
//   OPC_*    7-bit major opcodes used when assembling words
//   ALUOP_*  4-bit {insn[30], funct3} codes, as the I-type ALU decoder recovers them
//   enc_state_e  encoder FSM state encoding
package rv32i_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALUOP_ADDI  = 4'b0000;
  localparam logic [3:0] ALUOP_SLLI  = 4'b0001;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0010;
  localparam logic [3:0] ALUOP_SLTIU = 4'b0011;
  localparam logic [3:0] ALUOP_XORI  = 4'b0100;
  localparam logic [3:0] ALUOP_SRLI  = 4'b0101;
  localparam logic [3:0] ALUOP_ORI   = 4'b0110;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0111;
  localparam logic [3:0] ALUOP_SRAI  = 4'b1101;

  // ST_ERR is the one-cycle reject state that drives the err pulse.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2,
    ST_ERR   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/iinsn_alu_encoder_if.sv
// iinsn_alu_encoder_if: request and instruction-word handshakes of the encoder.
//   request side : req_valid/req_ready, alu_op, rd, rs1, imm
//   word side    : insn_valid/insn_ready, insn, insn_last, err
//   modport slave  - the encoder
//   modport master - the requester / word consumer
interface iinsn_alu_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [31:0] imm;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic        insn_last;
  logic        err;

  modport slave (
    input  req_valid, alu_op, rd, rs1, imm, insn_ready,
    output req_ready, insn_valid, insn, insn_last, err
  );

  modport master (
    output req_valid, alu_op, rd, rs1, imm, insn_ready,
    input  req_ready, insn_valid, insn, insn_last, err
  );
endinterface

// File: rtl/imm_range_check.sv
// imm_range_check: combinational legality / immediate-range check for OP-IMM.
//   alu_op   in  4   {insn[30], funct3}
//   imm      in  32  immediate (shamt for shifts)
//   op_legal out 1   alu_op is one of the nine OP-IMM operations
//   fits     out 1   immediate encodable in a single word
//   is_shift out 1   SLLI/SRLI/SRAI
module imm_range_check
  import rv32i_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [31:0] imm,
  output logic        op_legal,
  output logic        fits,
  output logic        is_shift
);

  always_comb begin
    op_legal = 1'b0;
    is_shift = 1'b0;
    case (alu_op)
      ALUOP_ADDI, ALUOP_SLTI, ALUOP_SLTIU, ALUOP_XORI,
      ALUOP_ORI, ALUOP_ANDI:               op_legal = 1'b1;
      ALUOP_SLLI, ALUOP_SRLI, ALUOP_SRAI: begin
        op_legal = 1'b1;
        is_shift = 1'b1;
      end
      default: ;
    endcase
  end

  // Shifts take an unsigned 5-bit shamt; everything else a sign-extended
  // 12-bit immediate, i.e. bits 31..11 must all equal the sign bit.
  assign fits = is_shift ? (imm[31:5] == 27'd0)
                         : ((&imm[31:11]) | ~(|imm[31:11]));

endmodule

// File: rtl/iinsn_alu_encoder.sv
// iinsn_alu_encoder: builds RV32I OP-IMM words (ADDI..SRAI) from fields.
// One registered output stage; emits a single word per request, or LUI+ADDI
// for a wide load-immediate when IINSN_ENC_LI_EXPAND_EN is defined.
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   bus (slave)  req_valid/req_ready + alu_op/rd/rs1/imm in,
//                insn_valid/insn_ready + insn/insn_last out, err pulse out
// Macro IINSN_ENC_LI_EXPAND_EN: out-of-range ADDI with rs1==x0 expands to
// LUI (+ ADDI when the low 12 bits are non-zero). Undefined: such requests
// are rejected and insn_last is 1 on every valid word.
module iinsn_alu_encoder
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  iinsn_alu_encoder_if.slave bus
);

  enc_state_e  state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic        op_legal, fits, is_shift;
  logic        accept;
  logic [11:0] imm_fld;
  logic [31:0] direct_word;

  imm_range_check u_chk (
    .alu_op   (bus.alu_op),
    .imm      (bus.imm),
    .op_legal (op_legal),
    .fits     (fits),
    .is_shift (is_shift)
  );

  assign bus.req_ready = (state_q == ST_IDLE) & ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  // Shift immediates carry insn[30] (SRAI) in the funct7 slot.
  assign imm_fld     = is_shift ? {1'b0, bus.alu_op[3], 5'b0, bus.imm[4:0]}
                                : bus.imm[11:0];
  assign direct_word = {imm_fld, bus.rs1, bus.alu_op[2:0], bus.rd, OPC_OP_IMM};

`ifdef IINSN_ENC_LI_EXPAND_EN
  logic        last_q, last_d;
  logic [31:0] w2_q, w2_d;
  logic [19:0] hi;
  logic        can_expand;

  // ADDI sign-extends its 12 bits, so LUI must pre-compensate by +1 when lo[11] is set.
  assign hi         = bus.imm[31:12] + {19'b0, bus.imm[11]};
  assign can_expand = (bus.alu_op == ALUOP_ADDI) && (bus.rs1 == 5'd0);
`endif

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
`ifdef IINSN_ENC_LI_EXPAND_EN
    last_d  = last_q;
    w2_d    = w2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_legal && fits) begin
            insn_d  = direct_word;
`ifdef IINSN_ENC_LI_EXPAND_EN
            last_d  = 1'b1;
`endif
            state_d = ST_EMIT1;
          end
`ifdef IINSN_ENC_LI_EXPAND_EN
          else if (can_expand) begin
            insn_d  = {hi, bus.rd, OPC_LUI};
            w2_d    = {bus.imm[11:0], bus.rd, 3'b000, bus.rd, OPC_OP_IMM};
            last_d  = (bus.imm[11:0] == 12'd0);
            state_d = ST_EMIT1;
          end
`endif
          else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_EMIT1: begin
        if (bus.insn_ready) begin
`ifdef IINSN_ENC_LI_EXPAND_EN
          if (!last_q) begin
            insn_d  = w2_q;
            last_d  = 1'b1;
            state_d = ST_EMIT2;
          end else
`endif
          state_d = ST_IDLE;
        end
      end
`ifdef IINSN_ENC_LI_EXPAND_EN
      ST_EMIT2: begin
        if (bus.insn_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;  // ST_ERR lasts exactly one cycle
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      insn_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
    end
  end

`ifdef IINSN_ENC_LI_EXPAND_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b0;
      w2_q   <= 32'd0;
    end else begin
      last_q <= last_d;
      w2_q   <= w2_d;
    end
  end
`endif

  assign bus.insn_valid = (state_q == ST_EMIT1) || (state_q == ST_EMIT2);
  assign bus.err        = (state_q == ST_ERR);
  assign bus.insn       = insn_q;
`ifdef IINSN_ENC_LI_EXPAND_EN
  assign bus.insn_last  = bus.insn_valid & last_q;
`else
  assign bus.insn_last  = bus.insn_valid;
`endif

endmodule

// File: tb/tb_iinsn_alu_encoder.sv
// Bench for iinsn_alu_encoder: directed cases pinned to literal words, then
// randomized requests with random consumer backpressure. A cycle-level
// scoreboard of expected words/err pulses is filled from a spec-level model
// and compared against the DUT on every falling edge.
module tb_iinsn_alu_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iinsn_alu_encoder_if bus ();

  iinsn_alu_encoder dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_err;
    logic [31:0] w;
    logic        last;
  } exp_t;
  exp_t q[$];

  int bp_mode = 0;  // 0: random insn_ready, 1: hold insn_ready low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: returns number of words (0 = rejected).
  function automatic int model(input logic [3:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [31:0] imm,
                               output logic [31:0] w1, output logic [31:0] w2);
    int s;
    logic [31:0] base, lo, hi;
    w1 = 32'd0;
    w2 = 32'd0;
    base = ({27'd0, rs1} << 15) | ({29'd0, op[2:0]} << 12) | ({27'd0, rd} << 7) | 32'h13;
    if (!(op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h1, 4'h5, 4'hD})) return 0;
    if (op inside {4'h1, 4'h5, 4'hD}) begin
      if (imm > 32'd31) return 0;
      w1 = base | (imm << 20) | (op[3] ? 32'h4000_0000 : 32'd0);
      return 1;
    end
    s = $signed(imm);
    if (s >= -2048 && s <= 2047) begin
      w1 = base | (imm << 20);
      return 1;
    end
`ifdef IINSN_ENC_LI_EXPAND_EN
    if (op == 4'h0 && rs1 == 5'd0) begin
      lo = imm & 32'hFFF;
      hi = (imm + 32'h800) >> 12;
      w1 = (hi << 12) | ({27'd0, rd} << 7) | 32'h37;
      if (lo == 32'd0) return 1;
      w2 = (lo << 20) | ({27'd0, rd} << 15) | ({27'd0, rd} << 7) | 32'h13;
      return 2;
    end
`endif
    return 0;
  endfunction

  // Consumer backpressure.
  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) bus.insn_ready = 1'b0;
    else              bus.insn_ready = ($urandom_range(0, 9) < 7);
  end

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    logic [31:0] w1, w2;
    int n;
    if (rst) begin
      q.delete();
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_insn_valid", {31'd0, bus.insn_valid}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_insn", bus.insn, 32'd0);
      chk("rst_insn_last", {31'd0, bus.insn_last}, 32'd0);
    end else begin
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, q.size() == 0});
      if (q.size() != 0 && q[0].is_err) begin
        chk("err_pulse", {31'd0, bus.err}, 32'd1);
        chk("err_no_valid", {31'd0, bus.insn_valid}, 32'd0);
        void'(q.pop_front());
      end else begin
        chk("err_idle", {31'd0, bus.err}, 32'd0);
        if (q.size() != 0) begin
          chk("insn_valid", {31'd0, bus.insn_valid}, 32'd1);
          chk("insn", bus.insn, q[0].w);
          chk("insn_last", {31'd0, bus.insn_last}, {31'd0, q[0].last});
          if (bus.insn_ready) void'(q.pop_front());
        end else begin
          chk("insn_valid_idle", {31'd0, bus.insn_valid}, 32'd0);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        n = model(bus.alu_op, bus.rd, bus.rs1, bus.imm, w1, w2);
        if (n == 0) q.push_back('{1'b1, 32'd0, 1'b0});
        else if (n == 1) q.push_back('{1'b0, w1, 1'b1});
        else begin
          q.push_back('{1'b0, w1, 1'b0});
          q.push_back('{1'b0, w2, 1'b1});
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [31:0] im);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.alu_op    = op;
    bus.rd        = d;
    bus.rs1       = s1;
    bus.imm       = im;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(q.size() == 0 && bus.req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d words still pending, required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [3:0] op, input logic [4:0] d,
                     input logic [4:0] s1, input logic [31:0] im,
                     input int en, input logic [31:0] ew1, input logic [31:0] ew2);
    logic [31:0] w1, w2;
    int n;
    n = model(op, d, s1, im, w1, w2);
    chk({name, "_n"}, n, en);
    if (en >= 1) chk({name, "_w1"}, w1, ew1);
    if (en == 2) chk({name, "_w2"}, w2, ew2);
  endtask

  logic [31:0] bnd [8] = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF,
                           32'd31, 32'd32, 32'h80000000, 32'h7FFFFFFF};
  logic [3:0]  legal [9] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h1, 4'h5, 4'hD};

  initial begin
    logic [31:0] im;
    logic [3:0]  op;
    bus.req_valid  = 1'b0;
    bus.alu_op     = 4'd0;
    bus.rd         = 5'd0;
    bus.rs1        = 5'd0;
    bus.imm        = 32'd0;
    bus.insn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pinned to hand-encoded words.
    pin("addi_m1", 4'h0, 5'd5, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF00293, 32'd0);
    pin("srai",    4'hD, 5'd1, 5'd2, 32'd3,        1, 32'h40315093, 32'd0);
    pin("slli32",  4'h1, 5'd1, 5'd2, 32'd32,       0, 32'd0, 32'd0);
    pin("op1000",  4'h8, 5'd1, 5'd2, 32'd0,        0, 32'd0, 32'd0);
    pin("op1011",  4'hB, 5'd1, 5'd2, 32'd0,        0, 32'd0, 32'd0);
    pin("addi_rs1", 4'h0, 5'd3, 5'd4, 32'h12345FFF, 0, 32'd0, 32'd0);
`ifdef IINSN_ENC_LI_EXPAND_EN
    pin("li_exp",  4'h0, 5'd10, 5'd0, 32'h12345FFF, 2, 32'h12346537, 32'hFFF50513);
    pin("li_lui",  4'h0, 5'd7,  5'd0, 32'h7FFFF000, 1, 32'h7FFFF3B7, 32'd0);
`else
    pin("li_exp",  4'h0, 5'd10, 5'd0, 32'h12345FFF, 0, 32'd0, 32'd0);
    pin("li_lui",  4'h0, 5'd7,  5'd0, 32'h7FFFF000, 0, 32'd0, 32'd0);
`endif

    // Directed traffic through the DUT.
    send(4'h0, 5'd5, 5'd0, 32'hFFFFFFFF);  wait_idle();
    send(4'hD, 5'd1, 5'd2, 32'd3);         wait_idle();
    send(4'h1, 5'd1, 5'd2, 32'd32);        wait_idle();
    send(4'h8, 5'd1, 5'd2, 32'd0);         wait_idle();
    send(4'hB, 5'd1, 5'd2, 32'd0);         wait_idle();
    send(4'h0, 5'd7, 5'd0, 32'h7FFFF000);  wait_idle();
    send(4'h0, 5'd10, 5'd0, 32'h12345FFF); wait_idle();

    // Backpressure on the expanding request.
    bp_mode = 1;
    send(4'h0, 5'd10, 5'd0, 32'h12345FFF);
    repeat (3) @(posedge clk);
    #1 bp_mode = 0;
    wait_idle();

    // Reset while a word is held.
    bp_mode = 1;
    send(4'h0, 5'd10, 5'd0, 32'h12345FFF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_insn_valid", {31'd0, bus.insn_valid}, 32'd0);
    chk("arst_insn", bus.insn, 32'd0);
    chk("arst_insn_last", {31'd0, bus.insn_last}, 32'd0);
    chk("arst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bp_mode = 0;
    send(4'h0, 5'd3, 5'd0, 32'd5);
    wait_idle();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) op = legal[$urandom_range(0, 8)];
      else                           op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: im = $urandom_range(0, 31);
        1: im = $urandom_range(0, 63);
        2: im = $urandom;
        3: im = bnd[$urandom_range(0, 7)];
        4: im = $urandom & 32'hFFFFF000;
        5: im = 32'd0 - $urandom_range(0, 3000);
        6: im = $urandom & 32'hFFF;
        default: im = $urandom_range(2040, 2060);
      endcase
      send(op, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), im);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
